mem_access_stage: RTL and testbench
===================================

Name: mem_access_stage

Overview:
- MIPS MEM stage, directly downstream of the execution stage.
- Registers EX results (ALU result, branch flag and target, write-register index from the RegDst mux) into an EX/MEM register.
- Performs the load or store through a req/ack data-memory handshake, stalling upstream while the access is outstanding.
- Produces the MEM/WB register and the branch redirect (pc_src) for fetch.

Parameters:
ALIGN_CHECK, 1, 1 = word accesses with addr[1:0]!=0 fault instead of issuing
WAIT_LIMIT, 0, max cycles in ACCESS before timeout fault; 0 = unlimited

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  synchronous, active-high
ex_valid  in  1  EX holds a real instruction
ex_alu_result  in  32  ALU result / memory address
ex_store_data  in  32  rt value for stores
ex_write_reg  in  5  destination register
ex_mem_read  in  1  load
ex_mem_write  in  1  store
ex_reg_write  in  1  writes register file
ex_mem_to_reg  in  1  WB selects load data
ex_branch  in  1  ALU branch-taken flag
ex_branch_target  in  32  branch adder output
flush  in  1  discard instruction being captured this cycle
stall  out  1  hold IF/ID/EX
dmem_req  out  1  access request
dmem_we  out  1  1 = store
dmem_addr  out  32  word address
dmem_wdata  out  32  store data
dmem_rdata  in  32  load data, valid with ack
dmem_ack  in  1  access complete this cycle
pc_src  out  1  take branch
pc_branch_target  out  32  redirect PC
wb_valid  out  1  MEM/WB holds an instruction
wb_reg_write  out  1  register write enable
wb_write_reg  out  5  destination
wb_data  out  32  rdata if mem_to_reg else alu_result
wb_fault  out  1  misaligned or timeout

Behaviour:
- Reset (sync, high): state IDLE; all EX/MEM and MEM/WB fields 0; all outputs 0. Reset mid-access drops dmem_req next edge. An ack arriving after reset is ignored.
- stall = (state==ACCESS) && !dmem_ack, combinational. No other stall source.
- EX/MEM capture, every edge with stall=0:
  - fields <= ex_*.
  - exm_valid <= ex_valid && !flush.
  - With stall=1, EX/MEM holds.
- Store priority: mem_read && mem_write together = store.
- States: IDLE, ACCESS.
- IDLE, captured instruction is a valid mem op:
  - Aligned (or ALIGN_CHECK=0): next state ACCESS; dmem_req=1, dmem_we, dmem_addr, dmem_wdata registered at the same edge.
  - Misaligned: stays IDLE, no request, faults at WB.
- ACCESS:
  - Request outputs stable until an edge samples dmem_ack=1.
  - That edge: req<=0, MEM/WB loaded (load data from dmem_rdata), state<=IDLE.
  - If ack is sampled high together with a new EX capture of a mem op, the new access issues at that edge (state stays ACCESS, back-to-back).
- Latency: EX to WB is 2 edges with zero-wait memory (ack in first ACCESS cycle), +1 per wait cycle. Non-mem ops: 2 edges, never stall.
- MEM/WB (edge when the exm instruction completes; otherwise wb_valid<=0, a bubble):
  - wb_valid=exm_valid.
  - wb_reg_write=exm_reg_write && !fault.
  - wb_fault=1 for one cycle on a fault.
- Flush: affects only the capture. An access already in ACCESS always completes.
- pc_src = exm_valid && exm_branch (from EX/MEM, combinational); pc_branch_target = exm_branch_target.
- Timeout: WAIT_LIMIT>0 and the counter reaches WAIT_LIMIT in ACCESS → req<=0, IDLE, wb_fault=1, reg write suppressed. The counter clears on entry to ACCESS.
- dmem_ack in IDLE: ignored.

Decomposition:
- Shared package (mips_pkg): state encoding IDLE/ACCESS, WORD_W=32, REG_IDX_W=5.
- One sub-module: ex_mem_reg, the EX/MEM register with enable (!stall) and flush-to-bubble.
- FSM and MEM/WB register stay in the top.

Test Plan:
- ALU op, ex_alu_result=0x0000_0010, reg_write=1, write_reg=5 → 2 edges later wb_valid=1, wb_write_reg=5, wb_data=0x10; stall never 1.
- Load addr 0x40, dmem ack after 3 wait cycles, rdata=0xDEADBEEF → stall high exactly 3 cycles, dmem_addr=0x40 stable, wb_data=0xDEADBEEF, then wb_valid=1.
- Store addr 0x44, data 0x1234, immediate ack, followed by a load to 0x48 → back-to-back requests, dmem_we 1 then 0, no stall cycle.
- Load addr 0x42 (ALIGN_CHECK=1) → no dmem_req, wb_fault=1, wb_reg_write=0.
- ex_branch=1, target 0x100, flush asserted with the next instruction → pc_src=1 with target 0x100 one cycle; flushed instruction gives wb_valid=0.
- Reset asserted in the 2nd ACCESS cycle, ack the following cycle → dmem_req=0 after the reset edge; all wb outputs 0; late ack causes no WB.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared types for the MIPS MEM stage: FSM encoding, datapath widths and the
// EX/MEM register layout.
package mips_pkg;

  localparam int WORD_W    = 32;
  localparam int REG_IDX_W = 5;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } mem_state_e;

  typedef struct packed {
    logic                 valid;
    logic [WORD_W-1:0]    alu_result;
    logic [WORD_W-1:0]    store_data;
    logic [REG_IDX_W-1:0] write_reg;
    logic                 mem_read;
    logic                 mem_write;
    logic                 reg_write;
    logic                 mem_to_reg;
    logic                 branch;
    logic [WORD_W-1:0]    branch_target;
  } ex_mem_t;

  localparam int EX_MEM_W = $bits(ex_mem_t);

  function automatic logic is_misaligned(input logic [WORD_W-1:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register: loads on enable, turns a flushed capture into a
// bubble, and can drop the held instruction when an access is abandoned.
module ex_mem_reg
  import mips_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic                flush,
  input  logic                clear,
  input  logic [EX_MEM_W-1:0] d,
  output logic [EX_MEM_W-1:0] q
);

  ex_mem_t d_s;
  ex_mem_t q_s;

  assign d_s = ex_mem_t'(d);
  assign q   = q_s;

  always_ff @(posedge clk) begin
    if (reset) begin
      q_s <= '0;
    end else if (en) begin
      q_s       <= d_s;
      q_s.valid <= d_s.valid && !flush;
    end else if (clear) begin
      q_s.valid <= 1'b0;
    end
  end

endmodule

// File: rtl/mem_access_stage.sv
// MIPS MEM stage: EX/MEM register, data-memory req/ack sequencing with
// upstream stall, MEM/WB register and branch redirect.
//
//   state  | meaning
//   IDLE   | no access outstanding; EX/MEM instruction retires next edge
//   ACCESS | dmem_req held, waiting for dmem_ack (or timeout)
module mem_access_stage
  import mips_pkg::*;
#(
  parameter bit          ALIGN_CHECK = 1'b1,
  parameter int unsigned WAIT_LIMIT  = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_valid,
  input  logic [31:0] ex_alu_result,
  input  logic [31:0] ex_store_data,
  input  logic [4:0]  ex_write_reg,
  input  logic        ex_mem_read,
  input  logic        ex_mem_write,
  input  logic        ex_reg_write,
  input  logic        ex_mem_to_reg,
  input  logic        ex_branch,
  input  logic [31:0] ex_branch_target,
  input  logic        flush,
  output logic        stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        pc_src,
  output logic [31:0] pc_branch_target,
  output logic        wb_valid,
  output logic        wb_reg_write,
  output logic [4:0]  wb_write_reg,
  output logic [31:0] wb_data,
  output logic        wb_fault
);

  localparam int TMR_W = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT + 1) : 1;

  mem_state_e          state;
  logic [TMR_W-1:0]    wait_tmr;
  ex_mem_t             ex_d;
  ex_mem_t             exm;
  logic [EX_MEM_W-1:0] exm_bits;
  logic                issue;
  logic                exm_misaligned;
  logic                timeout_hit;
  logic                exm_clear;

  always_comb begin
    ex_d               = '0;
    ex_d.valid         = ex_valid;
    ex_d.alu_result    = ex_alu_result;
    ex_d.store_data    = ex_store_data;
    ex_d.write_reg     = ex_write_reg;
    ex_d.mem_read      = ex_mem_read;
    ex_d.mem_write     = ex_mem_write;
    ex_d.reg_write     = ex_reg_write;
    ex_d.mem_to_reg    = ex_mem_to_reg;
    ex_d.branch        = ex_branch;
    ex_d.branch_target = ex_branch_target;
  end

  ex_mem_reg u_ex_mem_reg (
    .clk   (clk),
    .reset (reset),
    .en    (!stall),
    .flush (flush),
    .clear (exm_clear),
    .d     (ex_d),
    .q     (exm_bits)
  );

  assign exm = ex_mem_t'(exm_bits);

  assign stall            = (state == ACCESS) && !dmem_ack;
  assign pc_src           = exm.valid && exm.branch;
  assign pc_branch_target = exm.branch_target;

  // EX/MEM holds the issued instruction for the whole access, so the request
  // fields are taken straight from it and stay stable until the ack edge.
  assign dmem_we    = exm.mem_write;
  assign dmem_addr  = exm.alu_result;
  assign dmem_wdata = exm.store_data;

  always_comb begin
    issue = !stall && ex_valid && !flush && (ex_mem_read || ex_mem_write) &&
            !(ALIGN_CHECK && is_misaligned(ex_alu_result));
    exm_misaligned = ALIGN_CHECK && (exm.mem_read || exm.mem_write) &&
                     is_misaligned(exm.alu_result);
    timeout_hit = (WAIT_LIMIT > 0) && (wait_tmr == TMR_W'(1));
    exm_clear   = (state == ACCESS) && !dmem_ack && timeout_hit;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      wait_tmr     <= '0;
      dmem_req     <= 1'b0;
      wb_valid     <= 1'b0;
      wb_reg_write <= 1'b0;
      wb_write_reg <= '0;
      wb_data      <= '0;
      wb_fault     <= 1'b0;
    end else begin
      wb_valid     <= 1'b0;
      wb_reg_write <= 1'b0;
      wb_fault     <= 1'b0;
      case (state)
        IDLE: begin
          wb_valid     <= exm.valid;
          wb_reg_write <= exm.valid && exm.reg_write && !exm_misaligned;
          wb_write_reg <= exm.write_reg;
          wb_data      <= exm.alu_result;
          wb_fault     <= exm.valid && exm_misaligned;
        end
        ACCESS: begin
          if (dmem_ack) begin
            state        <= IDLE;
            dmem_req     <= 1'b0;
            wb_valid     <= exm.valid;
            wb_reg_write <= exm.valid && exm.reg_write;
            wb_write_reg <= exm.write_reg;
            wb_data      <= exm.mem_to_reg ? dmem_rdata : exm.alu_result;
          end else if (timeout_hit) begin
            state        <= IDLE;
            dmem_req     <= 1'b0;
            wb_valid     <= exm.valid;
            wb_write_reg <= exm.write_reg;
            wb_data      <= exm.alu_result;
            wb_fault     <= 1'b1;
          end else begin
            wait_tmr <= wait_tmr - TMR_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
      if (issue) begin
        state    <= ACCESS;
        dmem_req <= 1'b1;
        wait_tmr <= TMR_W'(WAIT_LIMIT);
      end
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: ALU pass-through, waited load,
// back-to-back store/load, misaligned fault, branch+flush, reset mid-access,
// and a timeout on a second instance with a short wait limit.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_valid;
  logic [31:0] ex_alu_result;
  logic [31:0] ex_store_data;
  logic [4:0]  ex_write_reg;
  logic        ex_mem_read;
  logic        ex_mem_write;
  logic        ex_reg_write;
  logic        ex_mem_to_reg;
  logic        ex_branch;
  logic [31:0] ex_branch_target;
  logic        flush;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;

  logic        stall, dmem_req, dmem_we, pc_src, wb_valid, wb_reg_write, wb_fault;
  logic [31:0] dmem_addr, dmem_wdata, pc_branch_target, wb_data;
  logic [4:0]  wb_write_reg;

  logic        t_stall, t_dmem_req, t_dmem_we, t_pc_src, t_wb_valid, t_wb_reg_write, t_wb_fault;
  logic [31:0] t_dmem_addr, t_dmem_wdata, t_pc_branch_target, t_wb_data;
  logic [4:0]  t_wb_write_reg;

  int n_assert = 0;
  int n_fail   = 0;
  int stall_cycles;

  always #5 clk = ~clk;

  mem_access_stage u_dut (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_alu_result(ex_alu_result),
    .ex_store_data(ex_store_data), .ex_write_reg(ex_write_reg), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_reg_write(ex_reg_write), .ex_mem_to_reg(ex_mem_to_reg),
    .ex_branch(ex_branch), .ex_branch_target(ex_branch_target), .flush(flush),
    .stall(stall), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .pc_src(pc_src), .pc_branch_target(pc_branch_target), .wb_valid(wb_valid),
    .wb_reg_write(wb_reg_write), .wb_write_reg(wb_write_reg), .wb_data(wb_data),
    .wb_fault(wb_fault)
  );

  mem_access_stage #(.ALIGN_CHECK(1'b1), .WAIT_LIMIT(2)) u_dut_to (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_alu_result(ex_alu_result),
    .ex_store_data(ex_store_data), .ex_write_reg(ex_write_reg), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_reg_write(ex_reg_write), .ex_mem_to_reg(ex_mem_to_reg),
    .ex_branch(ex_branch), .ex_branch_target(ex_branch_target), .flush(flush),
    .stall(t_stall), .dmem_req(t_dmem_req), .dmem_we(t_dmem_we), .dmem_addr(t_dmem_addr),
    .dmem_wdata(t_dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .pc_src(t_pc_src), .pc_branch_target(t_pc_branch_target), .wb_valid(t_wb_valid),
    .wb_reg_write(t_wb_reg_write), .wb_write_reg(t_wb_write_reg), .wb_data(t_wb_data),
    .wb_fault(t_wb_fault)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bubble();
    ex_valid = 0; ex_alu_result = '0; ex_store_data = '0; ex_write_reg = '0;
    ex_mem_read = 0; ex_mem_write = 0; ex_reg_write = 0; ex_mem_to_reg = 0;
    ex_branch = 0; ex_branch_target = '0; flush = 0;
  endtask

  task automatic drive_load(input logic [31:0] addr, input logic [4:0] rd);
    bubble();
    ex_valid = 1; ex_alu_result = addr; ex_write_reg = rd;
    ex_mem_read = 1; ex_mem_to_reg = 1; ex_reg_write = 1;
  endtask

  initial begin
    bubble();
    dmem_ack = 0; dmem_rdata = '0; reset = 1;
    step(); step();
    chk("rst_stall", stall, 0);
    chk("rst_req", dmem_req, 0);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_wb_fault", wb_fault, 0);
    chk("rst_pc_src", pc_src, 0);
    reset = 0;

    // ALU op retires two edges later without stalling
    ex_valid = 1; ex_alu_result = 32'h10; ex_reg_write = 1; ex_write_reg = 5;
    step();
    bubble();
    #1 chk("alu_stall", stall, 0);
    step();
    chk("alu_wb_valid", wb_valid, 1);
    chk("alu_wb_reg", wb_write_reg, 5);
    chk("alu_wb_data", wb_data, 32'h10);
    chk("alu_wb_we", wb_reg_write, 1);
    chk("alu_stall2", stall, 0);

    // load with 3 wait cycles
    drive_load(32'h40, 7);
    step();
    bubble();
    chk("ld_req", dmem_req, 1);
    chk("ld_we", dmem_we, 0);
    stall_cycles = 0;
    for (int i = 0; i < 3; i++) begin
      if (stall) stall_cycles++;
      chk("ld_addr_stable", dmem_addr, 32'h40);
      step();
    end
    dmem_ack = 1; dmem_rdata = 32'hDEADBEEF;
    #1;
    if (stall) stall_cycles++;
    chk("ld_stall_cycles", stall_cycles, 3);
    chk("ld_req_held", dmem_req, 1);
    step();
    dmem_ack = 0;
    chk("ld_wb_valid", wb_valid, 1);
    chk("ld_wb_data", wb_data, 32'hDEADBEEF);
    chk("ld_wb_reg", wb_write_reg, 7);
    chk("ld_req_drop", dmem_req, 0);

    // store with immediate ack followed by a load: back-to-back
    bubble();
    ex_valid = 1; ex_alu_result = 32'h44; ex_store_data = 32'h1234; ex_mem_write = 1;
    step();
    drive_load(32'h48, 9);
    dmem_ack = 1;
    #1;
    chk("st_we", dmem_we, 1);
    chk("st_addr", dmem_addr, 32'h44);
    chk("st_wdata", dmem_wdata, 32'h1234);
    chk("st_stall", stall, 0);
    step();
    bubble();
    dmem_rdata = 32'hCAFE0001;
    #1;
    chk("b2b_req", dmem_req, 1);
    chk("b2b_we", dmem_we, 0);
    chk("b2b_addr", dmem_addr, 32'h48);
    chk("b2b_stall", stall, 0);
    chk("st_wb_valid", wb_valid, 1);
    chk("st_wb_we", wb_reg_write, 0);
    step();
    dmem_ack = 0;
    chk("b2b_wb_valid", wb_valid, 1);
    chk("b2b_wb_data", wb_data, 32'hCAFE0001);
    chk("b2b_wb_reg", wb_write_reg, 9);
    chk("b2b_req_drop", dmem_req, 0);

    // misaligned load faults, never requests
    drive_load(32'h42, 3);
    step();
    bubble();
    chk("mis_req", dmem_req, 0);
    chk("mis_stall", stall, 0);
    step();
    chk("mis_wb_valid", wb_valid, 1);
    chk("mis_wb_fault", wb_fault, 1);
    chk("mis_wb_we", wb_reg_write, 0);
    step();
    chk("mis_fault_pulse", wb_fault, 0);

    // taken branch, following instruction flushed
    bubble();
    ex_valid = 1; ex_branch = 1; ex_branch_target = 32'h100;
    step();
    bubble();
    ex_valid = 1; ex_alu_result = 32'h55; ex_reg_write = 1; ex_write_reg = 4; flush = 1;
    chk("br_pc_src", pc_src, 1);
    chk("br_target", pc_branch_target, 32'h100);
    step();
    bubble();
    chk("br_pc_src_drop", pc_src, 0);
    chk("br_wb_valid", wb_valid, 1);
    step();
    chk("flush_wb_valid", wb_valid, 0);

    // reset during the 2nd access cycle; the late ack is ignored
    drive_load(32'h80, 2);
    step();
    bubble();
    chk("rma_req", dmem_req, 1);
    step();
    reset = 1;
    step();
    reset = 0;
    dmem_ack = 1; dmem_rdata = 32'h77;
    #1;
    chk("rma_req_drop", dmem_req, 0);
    chk("rma_stall", stall, 0);
    chk("rma_wb_valid", wb_valid, 0);
    chk("rma_wb_data", wb_data, 0);
    chk("rma_wb_reg", wb_write_reg, 0);
    step();
    dmem_ack = 0;
    chk("late_ack_wb_valid", wb_valid, 0);
    chk("late_ack_req", dmem_req, 0);

    // timeout after 2 ACCESS cycles on the WAIT_LIMIT=2 instance
    reset = 1;
    step();
    reset = 0;
    drive_load(32'h20, 6);
    step();
    bubble();
    chk("to_req", t_dmem_req, 1);
    step();
    chk("to_req_held", t_dmem_req, 1);
    chk("to_stall", t_stall, 1);
    step();
    chk("to_req_drop", t_dmem_req, 0);
    chk("to_wb_valid", t_wb_valid, 1);
    chk("to_wb_fault", t_wb_fault, 1);
    chk("to_wb_we", t_wb_reg_write, 0);
    chk("to_stall_drop", t_stall, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
